oreg_drain: RTL and testbench

OREG_DRAIN -- requirements
Module: oreg_drain

---
 rtl/oreg_pkg.sv | 20 ++
 rtl/oreg_shadow.sv | 30 +++
 rtl/oreg_drain.sv | 102 ++++++++++
 tb/tb_oreg_drain.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/oreg_pkg.sv
// Shared types and constants for the output-register drain block.
package oreg_pkg;

  typedef enum logic {
    StIdle,
    StStream
  } state_e;

  localparam int unsigned DefFWidth = 8;
  localparam int unsigned DefIWidth = 8;
  localparam int unsigned DefNRows  = 8;
  localparam int unsigned DefWordW  = DefFWidth + DefIWidth;
  localparam int unsigned DefIdxW   = $clog2(DefNRows);

  // Index width for a given row count; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/oreg_shadow.sv
// Shadow copy of the column output registers: parallel load, indexed read.
module oreg_shadow #(
  parameter int unsigned Width = 16,
  parameter int unsigned NRows = 8,
  parameter int unsigned IdxW  = 3
) (
  input  logic                   clk_i,
  input  logic                   load_i,
  input  logic [NRows*Width-1:0] data_i,
  input  logic [IdxW-1:0]        rd_idx_i,
  output logic [Width-1:0]       rd_data_o
);

  logic [Width-1:0] mem_q [NRows];

  // Capture every row at once; contents are don't-care until the first load.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      for (int r = 0; r < NRows; r++) begin
        mem_q[r] <= data_i[r*Width +: Width];
      end
    end
  end

  // Combinational read of the selected row.
  always_comb begin
    rd_data_o = mem_q[rd_idx_i];
  end

endmodule

// File: rtl/oreg_drain.sv
// Drains a column of output registers into a valid/ready word stream,
// with optional ReLU, after snapshotting them and pulsing their clear.
module oreg_drain
  import oreg_pkg::*;
#(
  parameter int unsigned F_WIDTH = DefFWidth,
  parameter int unsigned I_WIDTH = DefIWidth,
  parameter int unsigned N_ROWS  = DefNRows
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  start_i,
  input  logic                                  relu_i,
  input  logic [N_ROWS*(F_WIDTH+I_WIDTH)-1:0]   data_i,
  output logic                                  oreg_rst_o,
  output logic                                  busy_o,
  output logic [F_WIDTH+I_WIDTH-1:0]            out_data_o,
  output logic [idx_width(N_ROWS)-1:0]          out_idx_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  out_last_o,
  output logic                                  done_o
);

  localparam int unsigned W    = F_WIDTH + I_WIDTH;
  localparam int unsigned IdxW = idx_width(N_ROWS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_ROWS - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            relu_q;
  logic            oreg_rst_q;
  logic            done_q;
  logic            load;
  logic [W-1:0]    rd_word;

  // Snapshot only when a start is accepted; starts during a drain are ignored.
  assign load = (state_q == StIdle) && start_i;

  oreg_shadow #(
    .Width (W),
    .NRows (N_ROWS),
    .IdxW  (IdxW)
  ) u_shadow (
    .clk_i     (clk_i),
    .load_i    (load),
    .data_i    (data_i),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_word)
  );

  // Drain FSM with registered clear and completion pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      relu_q     <= 1'b0;
      oreg_rst_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      oreg_rst_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StStream;
            idx_q      <= '0;
            relu_q     <= relu_i;
            oreg_rst_q <= 1'b1;
          end
        end
        StStream: begin
          if (out_ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stream outputs follow the registered state; data is zeroed outside a drain.
  always_comb begin
    out_valid_o = (state_q == StStream);
    busy_o      = (state_q == StStream);
    out_idx_o   = idx_q;
    out_last_o  = out_valid_o && (idx_q == LastIdx);
    oreg_rst_o  = oreg_rst_q;
    done_o      = done_q;
    out_data_o  = '0;
    if (out_valid_o) begin
      out_data_o = (relu_q && rd_word[W-1]) ? '0 : rd_word;
    end
  end

endmodule

// File: tb/tb_oreg_drain.sv
// Scoreboard bench for oreg_drain: driver predicts beats and timing,
// an independent monitor checks every transferred beat and stall stability.
module tb_oreg_drain;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned W  = FW + IW;
  localparam int unsigned XW = 2;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n_i;
  logic           start_i;
  logic           relu_i;
  logic [N*W-1:0] data_i;
  logic           oreg_rst_o;
  logic           busy_o;
  logic [W-1:0]   out_data_o;
  logic [XW-1:0]  out_idx_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic           out_last_o;
  logic           done_o;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  oreg_drain #(
    .F_WIDTH (FW),
    .I_WIDTH (IW),
    .N_ROWS  (N)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .relu_i      (relu_i),
    .data_i      (data_i),
    .oreg_rst_o  (oreg_rst_o),
    .busy_o      (busy_o),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] relu_f(input logic [W-1:0] w, input logic r);
    if (r && ($signed(w) < 0)) return '0;
    return w;
  endfunction

  // Monitor: every transfer must match the head of the scoreboard.
  bit           held_v = 0;
  logic [W-1:0] held_d;
  logic [XW-1:0] held_i;
  logic         held_l;
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n_i) begin
      held_v = 0;
    end else begin
      if (held_v && out_valid_o) begin
        chk("stall_stable", {out_data_o, out_idx_o, out_last_o}, {held_d, held_i, held_l});
      end
      if (out_valid_o) begin
        if (out_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", out_data_o, b.data);
            chk("beat_idx", out_idx_o, b.idx);
            chk("beat_last", out_last_o, b.last);
          end
          held_v = 0;
        end else begin
          held_v = 1;
          held_d = out_data_o;
          held_i = out_idx_o;
          held_l = out_last_o;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  // mode 0: ready always; 1: random ready; 2: three-cycle stall at row 1.
  task automatic drain(input logic [N*W-1:0] dat, input logic relu, input int mode,
                       input bit mess, input bit restart);
    int remaining = N;
    int cyc = 0;
    int stall = 0;
    bit fin = 0;
    data_i  = dat;
    relu_i  = relu;
    start_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      exp_q.push_back('{data: relu_f(dat[r*W +: W], relu), idx: r, last: (r == N - 1)});
    end
    out_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    start_i = restart ? 1'($urandom_range(0, 1)) : 1'b0;
    relu_i  = 1'($urandom_range(0, 1));
    if (mess) data_i = {$urandom(), $urandom()};
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      cyc++;
      chk("oreg_rst", oreg_rst_o, (cyc == 1));
      if (remaining > 0) begin
        chk("stream_state", {out_valid_o, busy_o, done_o}, 3'b110);
        if (out_ready_i) remaining--;
      end else begin
        chk("done_state", {out_valid_o, busy_o, done_o, out_last_o}, 4'b0010);
        if (mode != 1) chk("done_latency", cyc, N + 1 + ((mode == 2) ? 3 : 0));
        fin = 1;
        break;
      end
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (remaining == N - 1 && stall < 3) begin
            out_ready_i = 1'b0;
            stall++;
          end else begin
            out_ready_i = 1'b1;
          end
        end
      endcase
      if (mess) data_i = {$urandom(), $urandom()};
      if (restart) start_i = 1'($urandom_range(0, 1));
    end
    if (!fin) chk("drain_timeout", 0, 1);
    start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_state", {out_valid_o, busy_o, done_o, oreg_rst_o}, 4'b0000);
    end
  endtask

  task automatic reset_mid_drain();
    data_i      = {$urandom(), $urandom()};
    relu_i      = 1'b0;
    out_ready_i = 1'b1;
    start_i     = 1'b1;
    for (int r = 0; r < N; r++) begin
      exp_q.push_back('{data: data_i[r*W +: W], idx: r, last: (r == N - 1)});
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("rst_async", {out_valid_o, busy_o, out_last_o, done_o, oreg_rst_o}, 5'b0);
    chk("rst_data", {out_data_o, out_idx_o}, '0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", {out_valid_o, busy_o, done_o}, 3'b000);
    end
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    idle(2);
  endtask

  localparam logic [N*W-1:0] T1 = {16'd4, 16'hFFFD, 16'd2, 16'd1};

  initial begin
    rst_n_i     = 1'b0;
    start_i     = 1'b0;
    relu_i      = 1'b0;
    data_i      = '0;
    out_ready_i = 1'b1;
    #2;
    chk("reset_ctrl", {out_valid_o, busy_o, out_last_o, done_o, oreg_rst_o}, 5'b0);
    chk("reset_data", {out_data_o, out_idx_o}, '0);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    idle(2);

    drain(T1, 1'b0, 0, 1'b0, 1'b0);  // 1, 2, -3, 4
    idle(1);
    drain(T1, 1'b1, 0, 1'b0, 1'b0);  // 1, 2, 0, 4
    idle(1);
    drain(T1, 1'b0, 2, 1'b0, 1'b0);  // stall at row 1
    idle(1);
    drain(T1, 1'b0, 0, 1'b1, 1'b1);  // data churn and ignored restarts
    drain(T1, 1'b1, 0, 1'b0, 1'b0);  // accepted in the done cycle
    idle(1);

    reset_mid_drain();
    drain(T1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);

    for (int k = 0; k < 24; k++) begin
      int gap;
      drain({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end

    idle(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
